// File: rtl/decode_stage.sv
// RV32I decode stage: one registered ALU request behind a valid/ready handshake.
// Define ID_ILLEGAL_TRAP_EN to register the illegal flag; otherwise illegal is tied to 0.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic        illegal
);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SLL  = 3'd1;
  localparam logic [2:0] ALU_SRL  = 3'd5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_shift;

  logic        dec_ok;
  logic [2:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_rd;
  logic        dec_we;

  logic        valid_q, valid_d;
  logic [2:0]  alu_op_q;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [4:0]  rd_q;
  logic        rd_we_q;
  logic        load;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign is_shift = (funct3 == ALU_SLL) || (funct3 == ALU_SRL);

  always_comb begin
    dec_ok = 1'b0;
    dec_op = ALU_ADD;
    dec_a  = 32'd0;
    dec_b  = 32'd0;
    unique case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          dec_ok = 1'b1;
          dec_op = funct3;
          dec_a  = rs1_data;
          dec_b  = rs2_data;
        end
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          // SRAI/odd shift encodings are not supported; only funct7 == 0 passes
          if (funct7 == 7'b0000000) begin
            dec_ok = 1'b1;
            dec_op = funct3;
            dec_a  = rs1_data;
            dec_b  = {27'd0, inst[24:20]};
          end
        end else begin
          dec_ok = 1'b1;
          dec_op = funct3;
          dec_a  = rs1_data;
          dec_b  = {{20{inst[31]}}, inst[31:20]};
        end
      end
      OPC_LUI: begin
        dec_ok = 1'b1;
        dec_op = ALU_ADD;
        dec_a  = 32'd0;
        dec_b  = {inst[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        dec_ok = 1'b1;
        dec_op = ALU_ADD;
        dec_a  = pc;
        dec_b  = {inst[31:12], 12'd0};
      end
      default: begin
        dec_ok = 1'b0;
      end
    endcase

    // Unsupported instructions collapse to a NOP with no writeback
    if (!dec_ok) begin
      dec_op = ALU_ADD;
      dec_a  = 32'd0;
      dec_b  = 32'd0;
    end
  end

  assign dec_rd = inst[11:7];
  assign dec_we = dec_ok && (dec_rd != 5'd0);

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      alu_op_q <= 3'd0;
      alu_a_q  <= 32'd0;
      alu_b_q  <= 32'd0;
      rd_q     <= 5'd0;
      rd_we_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        alu_op_q <= dec_op;
        alu_a_q  <= dec_a;
        alu_b_q  <= dec_b;
        rd_q     <= dec_rd;
        rd_we_q  <= dec_we;
      end
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (load) begin
      illegal_q <= !dec_ok;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign out_valid = valid_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rd        = rd_q;
  assign rd_we     = rd_we_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference decoder predicts each accepted
// instruction, and the prediction is compared when execute consumes the request.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .rd        (rd),
    .rd_we     (rd_we),
    .illegal   (illegal)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   rand_rdy   = 1'b0;
  bit   stall_prev = 1'b0;

  logic        h_valid;
  logic [2:0]  h_op;
  logic [31:0] h_a;
  logic [31:0] h_b;
  logic [4:0]  h_rd;
  logic        h_we;
  logic        h_ill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic ok;
    logic shift;
    logic [2:0] f3;
    f3    = i[14:12];
    shift = (f3 == 3'b001) || (f3 == 3'b101);
    ok    = 1'b0;
    e.op  = 3'd0;
    e.a   = 32'd0;
    e.b   = 32'd0;
    e.rd  = i[11:7];
    if (i[6:0] == 7'b0110011 && i[31:25] == 7'd0) begin
      ok = 1'b1; e.op = f3; e.a = r1; e.b = r2;
    end else if (i[6:0] == 7'b0010011 && !(shift && i[31:25] != 7'd0)) begin
      ok = 1'b1; e.op = f3; e.a = r1;
      e.b = shift ? 32'(i[24:20]) : 32'($signed(i[31:20]));
    end else if (i[6:0] == 7'b0110111) begin
      ok = 1'b1; e.b = {i[31:12], 12'h000};
    end else if (i[6:0] == 7'b0010111) begin
      ok = 1'b1; e.a = p; e.b = {i[31:12], 12'h000};
    end
    e.we = ok && (i[11:7] != 5'd0);
`ifdef ID_ILLEGAL_TRAP_EN
    e.ill = !ok;
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  // Negedge monitor: handshake bookkeeping, stall stability, scoreboard compare
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'(h_valid));
        check("stall_op",    32'(alu_op),    32'(h_op));
        check("stall_a",     alu_a,          h_a);
        check("stall_b",     alu_b,          h_b);
        check("stall_rd",    32'(rd),        32'(h_rd));
        check("stall_we",    32'(rd_we),     32'(h_we));
        check("stall_ill",   32'(illegal),   32'(h_ill));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_out", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("alu_op",  32'(alu_op),  32'(mon_e.op));
          check("alu_a",   alu_a,        mon_e.a);
          check("alu_b",   alu_b,        mon_e.b);
          check("rd",      32'(rd),      32'(mon_e.rd));
          check("rd_we",   32'(rd_we),   32'(mon_e.we));
          check("illegal", 32'(illegal), 32'(mon_e.ill));
        end
      end else if (flush && out_valid && sb_q.size() != 0) begin
        void'(sb_q.pop_front());
      end
      if (in_valid && in_ready && !flush)
        sb_q.push_back(ref_decode(inst, pc, rs1_data, rs2_data));
      stall_prev = out_valid && !out_ready && !flush;
      h_valid = out_valid; h_op = alu_op; h_a = alu_a; h_b = alu_b;
      h_rd = rd; h_we = rd_we; h_ill = illegal;
    end
  end

  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] r1, input logic [31:0] r2, input logic fl);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; inst = i; pc = p; rs1_data = r1; rs2_data = r2; flush = fl;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      done = in_ready || fl;
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    if (!done) check("handshake_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  logic [31:0] misc_q[$];
  logic [31:0] r;

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    flush = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_op",    32'(alu_op),    32'd0);
    check("rst_alu_a",     alu_a,          32'd0);
    check("rst_alu_b",     alu_b,          32'd0);
    check("rst_rd",        32'(rd),        32'd0);
    check("rst_rd_we",     32'(rd_we),     32'd0);
    check("rst_illegal",   32'(illegal),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // addi x1,x0,10
    send(32'h00A00093, 32'h0, 32'h0, 32'h0, 1'b0);
    check("addi_valid", 32'(out_valid), 32'd1);
    idle(2);

    // lui x4,0x12345 then auipc x5,1 at pc 0x100
    send(32'h12345237, 32'h40, 32'hDEAD_BEEF, 32'h1, 1'b0);
    send(32'h00001297, 32'h100, 32'h5555_5555, 32'h2, 1'b0);
    idle(2);

    // stall: hold add for 3 cycles while xori waits at the input
    out_ready = 1'b0;
    send(32'h002081B3, 32'h200, 32'd5, 32'd7, 1'b0);
    fork
      send(32'hFFF44393, 32'h204, 32'h0F0F_0F0F, 32'd0, 1'b0);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(3);

    // flush during srli x5,x6,3 handshake, then the same instruction normally
    send(32'h00335293, 32'h300, 32'h80, 32'd0, 1'b1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    send(32'h00335293, 32'h304, 32'h80, 32'd0, 1'b0);
    check("post_flush_valid", 32'(out_valid), 32'd1);
    idle(2);

    // sub, srai, lw, add x0, sltiu: unsupported forms and rd==0
    misc_q = '{32'h40208033, 32'h4030D093, 32'h00002083, 32'h00208033, 32'h8000B513};
    foreach (misc_q[k]) send(misc_q[k], 32'h400 + 32'(k * 4), 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    idle(2);

    // async reset in the middle of a stall
    out_ready = 1'b0;
    send(32'h002081B3, 32'h500, 32'd11, 32'd22, 1'b0);
    #2 rst = 1'b1;
    #1;
    sb_q.delete();
    stall_prev = 1'b0;
    check("amid_rst_valid", 32'(out_valid), 32'd0);
    check("amid_rst_op",    32'(alu_op),    32'd0);
    check("amid_rst_a",     alu_a,          32'd0);
    check("amid_rst_b",     alu_b,          32'd0);
    check("amid_rst_rd",    32'(rd),        32'd0);
    check("amid_rst_we",    32'(rd_we),     32'd0);
    check("amid_rst_ill",   32'(illegal),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    idle(1);

    // random mix with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      case ($urandom_range(0, 4))
        0: begin
          r[6:0] = 7'b0110011;
          r[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
        end
        1: begin
          r[6:0] = 7'b0010011;
          if (r[14:12] == 3'b001 || r[14:12] == 3'b101)
            r[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
        end
        2: r[6:0] = 7'b0110111;
        3: r[6:0] = 7'b0010111;
        default: ;
      endcase
      send(r, $urandom, $urandom, $urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit RV32I.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; the ports are listed below.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch holds a valid instruction.
- in_ready  output  1  stage accepts an instruction this cycle.
- inst  input  32  instruction word.
- pc  input  32  address of inst.
- rs1_data  input  32  register-file value for inst[19:15]; valid in the same cycle as inst.
- rs2_data  input  32  register-file value for inst[24:20]; valid in the same cycle as inst.
- flush  input  1  discard the held and incoming instruction.
- out_valid  output  1  the registered ALU request is valid.
- out_ready  input  1  the execute stage consumes the request.
- alu_op  output  3  ALU operation encoded with the `ALU_* codes: ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, OR=6, AND=7.
- alu_a  output  32  ALU operand a.
- alu_b  output  32  ALU operand b.
- rd  output  5  destination register.
- rd_we  output  1  writeback enable.
- illegal  output  1  the held instruction is unsupported.

Function
REQ-003 The block SHALL hold one pipeline register: in_ready = !out_valid || out_ready, combinationally.
REQ-004 A handshake (in_valid && in_ready && !flush) SHALL load the decoded fields and set out_valid=1 on the next edge (latency 1 cycle).
REQ-005 If out_valid && out_ready and no new handshake occurs, out_valid SHALL clear on the next edge.
REQ-006 While out_valid && !out_ready, all outputs SHALL remain stable.
REQ-007 flush SHALL clear out_valid on the next edge, override a simultaneous handshake, and leave the other output registers unchanged.
REQ-008 For OP (opcode 0110011) with funct7=0000000, the block SHALL decode alu_op=funct3, alu_a=rs1_data, alu_b=rs2_data, and rd_we=1.
REQ-009 For OP-IMM (0010011), the block SHALL decode alu_op=funct3, alu_a=rs1_data, alu_b=sign-extended inst[31:20], and rd_we=1.
REQ-010 For OP-IMM shifts (funct3=001 or 101), the block SHALL require inst[31:25]=0000000 and set alu_b={27'b0, inst[24:20]}.
REQ-011 For LUI (0110111), the block SHALL decode alu_op=ADD, alu_a=0, alu_b={inst[31:12],12'b0}, and rd_we=1.
REQ-012 For AUIPC (0010111), the block SHALL decode alu_op=ADD, alu_a=pc, alu_b={inst[31:12],12'b0}, and rd_we=1.
REQ-013 The block SHALL treat the following as unsupported: any other opcode, OP with funct7≠0 (SUB, SRA), and OP-IMM shifts with inst[31:25]≠0.
REQ-014 For an unsupported instruction, the block SHALL decode alu_op=ADD, alu_a=0, alu_b=0, and rd_we=0 (a NOP).
REQ-015 The block SHALL always set rd=inst[11:7], and SHALL force rd_we=0 when rd=0.

Reset
REQ-016 The block SHALL clear out_valid, alu_op, alu_a, alu_b, rd, rd_we, and illegal to 0 immediately on rst assertion, regardless of clk.
REQ-017 A reset asserted mid-stall SHALL drop the held instruction; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-018 When ID_ILLEGAL_TRAP_EN is defined, the block SHALL register illegal=1 with an unsupported instruction and illegal=0 with a supported one.
REQ-019 When ID_ILLEGAL_TRAP_EN is undefined, the block SHALL tie illegal to constant 0, and unsupported instructions SHALL pass silently as NOPs per REQ-014.

Verification
REQ-020 The bench SHALL cover: inst=0x00A00093 (addi x1,x0,10), rs1_data=0 -> next cycle out_valid=1, alu_op=0, alu_a=0, alu_b=10, rd=1, rd_we=1.
REQ-021 The bench SHALL cover: inst=0x12345237 (lui x4), then AUIPC at pc=0x100 with imm 0x1 -> first request alu_b=0x12345000, alu_a=0; second request alu_a=0x100, alu_b=0x1000.
REQ-022 The bench SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; out_ready=1 -> the queued instruction is accepted on the same edge, with no loss or duplication.
REQ-023 The bench SHALL cover: flush asserted during a handshake of srli x5,x6,3 -> out_valid=0 next cycle; the following instruction is decoded normally.
REQ-024 The bench SHALL cover: inst=0x40208033 (sub) with ID_ILLEGAL_TRAP_EN defined -> illegal=1, rd_we=0, alu_a=alu_b=0; without the macro -> illegal=0 and the same NOP.
REQ-025 The bench SHALL cover: rst asserted asynchronously mid-stall -> all outputs are 0 before the next clk edge.
